// File: rtl/mem_stage_sram.sv
// mem_stage_sram
// Memory stage of the 5-stage MIPS pipeline, between EX and WB/CP0.
// Holds one instruction, waits for the data-bus response of any load/store
// issued in EX, aligns and extends load data (including LWL/LWR merge), and
// hands the result to WB. Responses belonging to flushed instructions are
// swallowed so they cannot complete a younger instruction.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   es_to_ms_valid/bus   EX bundle in {side, exc, badvaddr, req, ld_type,
//                        addr_lo, rt_val, gr_we, dest, result, pc}
//   ms_allowin           MS can take a bundle this cycle
//   data_sram_data_ok    one-cycle response strobe, data_sram_rdata with it
//   flush                WB exception/ERET flush
//   ws_allowin           WB can accept
//   ms_to_ws_valid/bus   bundle to WB {side, exc, badvaddr, gr_we, dest,
//                        final_result, pc}
//   ms_fwd               {fwd_valid, fwd_blocked, gr_we, dest, final_result}

module mem_stage_sram #(
   parameter int SIDE_WD   = 46,
   parameter int ES_BUS_WD = SIDE_WD + 155,
   parameter int WS_BUS_WD = SIDE_WD + 117
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 es_to_ms_valid,
   input  logic [ES_BUS_WD-1:0] es_to_ms_bus,
   output logic                 ms_allowin,
   input  logic                 data_sram_data_ok,
   input  logic [31:0]          data_sram_rdata,
   input  logic                 flush,
   input  logic                 ws_allowin,
   output logic                 ms_to_ws_valid,
   output logic [WS_BUS_WD-1:0] ms_to_ws_bus,
   output logic [42:0]          ms_fwd
);

   // The req bit is only needed to choose WAIT/READY on entry, so the
   // latched copy of the bundle leaves it out.
   localparam int KEEP_WD = ES_BUS_WD - 1;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      WAIT  = 2'd1,
      READY = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [KEEP_WD-1:0] bundle_q;
   logic               discard_q, discard_d;
   logic               buf_valid_q, buf_valid_d;
   logic [31:0]        buf_q, buf_d;

   logic               ms_valid;
   logic               ready_go;
   logic               accept;
   logic               in_req;
   logic               own_resp;

   logic [SIDE_WD-1:0] side;
   logic [11:0]        exc;
   logic [31:0]        badvaddr;
   logic [2:0]         ld_type;
   logic [1:0]         addr_lo;
   logic [31:0]        rt_val;
   logic [3:0]         gr_we;
   logic [4:0]         dest;
   logic [31:0]        result;
   logic [31:0]        pc;

   logic [31:0]        load_data;
   logic [7:0]         load_byte;
   logic [15:0]        load_half;
   logic [31:0]        final_result;

   assign side     = bundle_q[KEEP_WD-1:154];
   assign exc      = bundle_q[153:142];
   assign badvaddr = bundle_q[141:110];
   assign ld_type  = bundle_q[109:107];
   assign addr_lo  = bundle_q[106:105];
   assign rt_val   = bundle_q[104:73];
   assign gr_we    = bundle_q[72:69];
   assign dest     = bundle_q[68:64];
   assign result   = bundle_q[63:32];
   assign pc       = bundle_q[31:0];

   assign ms_valid = (state_q != EMPTY);

   // A response only belongs to the held instruction when no stale
   // response is still owed from a flushed one.
   assign own_resp = (state_q == WAIT) && data_sram_data_ok && !discard_q;

   assign ready_go       = (state_q == READY) || own_resp;
   assign ms_allowin     = !ms_valid || (ready_go && ws_allowin);
   assign ms_to_ws_valid = ms_valid && ready_go && !flush;

   // An excepting bundle never waits, whatever EX claims about req.
   assign in_req = es_to_ms_bus[110] && (es_to_ms_bus[154:143] == 12'h000);
   assign accept = es_to_ms_valid && ms_allowin && !flush;

   // Next-state for the occupancy FSM, the stale-response flag and the
   // response buffer used when WB is not ready in the data_ok cycle.
   always_comb begin
      state_d     = state_q;
      discard_d   = discard_q;
      buf_valid_d = buf_valid_q;
      buf_d       = buf_q;

      if (data_sram_data_ok && discard_q) begin
         discard_d = 1'b0;
      end

      if (flush) begin
         state_d     = EMPTY;
         buf_valid_d = 1'b0;
         // The held instruction's response is still outstanding unless it
         // arrives in this very cycle.
         if ((state_q == WAIT) && !own_resp) begin
            discard_d = 1'b1;
         end
      end else if (accept) begin
         state_d     = in_req ? WAIT : READY;
         buf_valid_d = 1'b0;
      end else if (ms_valid && ready_go && ws_allowin) begin
         state_d     = EMPTY;
         buf_valid_d = 1'b0;
      end else if (own_resp) begin
         state_d     = READY;
         buf_valid_d = 1'b1;
         buf_d       = data_sram_rdata;
      end
   end

   // State registers; the bundle is only written when a new one is taken.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= EMPTY;
         discard_q   <= 1'b0;
         buf_valid_q <= 1'b0;
         buf_q       <= 32'h0;
         bundle_q    <= '0;
      end else begin
         state_q     <= state_d;
         discard_q   <= discard_d;
         buf_valid_q <= buf_valid_d;
         buf_q       <= buf_d;
         if (accept) begin
            bundle_q <= {es_to_ms_bus[ES_BUS_WD-1:111], es_to_ms_bus[109:0]};
         end
      end
   end

   // Load alignment and extension; LWL/LWR merge rdata with the old rt.
   always_comb begin
      load_data = buf_valid_q ? buf_q : data_sram_rdata;

      load_byte = load_data[7:0];
      case (addr_lo)
         2'd1:    load_byte = load_data[15:8];
         2'd2:    load_byte = load_data[23:16];
         2'd3:    load_byte = load_data[31:24];
         default: load_byte = load_data[7:0];
      endcase

      load_half = addr_lo[1] ? load_data[31:16] : load_data[15:0];

      final_result = result;
      case (ld_type)
         3'd1: final_result = {{24{load_byte[7]}}, load_byte};
         3'd2: final_result = {24'h0, load_byte};
         3'd3: final_result = {{16{load_half[15]}}, load_half};
         3'd4: final_result = {16'h0, load_half};
         3'd5: final_result = load_data;
         3'd6: begin
            case (addr_lo)
               2'd0:    final_result = {load_data[7:0],  rt_val[23:0]};
               2'd1:    final_result = {load_data[15:0], rt_val[15:0]};
               2'd2:    final_result = {load_data[23:0], rt_val[7:0]};
               default: final_result = load_data;
            endcase
         end
         3'd7: begin
            case (addr_lo)
               2'd1:    final_result = {rt_val[31:24], load_data[31:8]};
               2'd2:    final_result = {rt_val[31:16], load_data[31:16]};
               2'd3:    final_result = {rt_val[31:8],  load_data[31:24]};
               default: final_result = load_data;
            endcase
         end
         default: final_result = result;
      endcase
   end

   assign ms_to_ws_bus = {side, exc, badvaddr, gr_we, dest, final_result, pc};

   // Decode must stall on a matching dest while a load's data is missing.
   assign ms_fwd = {ms_valid && (|gr_we),
                    ms_valid && (ld_type != 3'd0) && !ready_go,
                    gr_we, dest, final_result};

endmodule

// File: tb/tb_mem_stage_sram.sv
// tb_mem_stage_sram
// Drives mem_stage_sram while acting as the data bus slave and as WB.
// Each accepted bundle that should reach WB has its expected fields pushed
// to a queue; an independent monitor pops and compares on every WB handshake.

module tb_mem_stage_sram;

   localparam int SIDE_WD   = 46;
   localparam int ES_BUS_WD = SIDE_WD + 155;
   localparam int WS_BUS_WD = SIDE_WD + 117;

   logic                 clk = 1'b0;
   logic                 resetn;
   logic                 es_to_ms_valid;
   logic [ES_BUS_WD-1:0] es_to_ms_bus;
   logic                 ms_allowin;
   logic                 data_sram_data_ok;
   logic [31:0]          data_sram_rdata;
   logic                 flush;
   logic                 ws_allowin;
   logic                 ms_to_ws_valid;
   logic [WS_BUS_WD-1:0] ms_to_ws_bus;
   logic [42:0]          ms_fwd;

   typedef struct {
      logic [31:0]        pc;
      logic [31:0]        value;
      logic [11:0]        exc;
      logic [31:0]        badvaddr;
      logic [3:0]         grWe;
      logic [4:0]         dest;
      logic [SIDE_WD-1:0] side;
   } expect_t;

   expect_t expQ[$];
   int      checks = 0;
   int      errors = 0;

   mem_stage_sram #(
      .SIDE_WD  (SIDE_WD),
      .ES_BUS_WD(ES_BUS_WD),
      .WS_BUS_WD(WS_BUS_WD)
   ) dut (
      .clk              (clk),
      .resetn           (resetn),
      .es_to_ms_valid   (es_to_ms_valid),
      .es_to_ms_bus     (es_to_ms_bus),
      .ms_allowin       (ms_allowin),
      .data_sram_data_ok(data_sram_data_ok),
      .data_sram_rdata  (data_sram_rdata),
      .flush            (flush),
      .ws_allowin       (ws_allowin),
      .ms_to_ws_valid   (ms_to_ws_valid),
      .ms_to_ws_bus     (ms_to_ws_bus),
      .ms_fwd           (ms_fwd)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, required, $time);
      end
   endtask

   function automatic logic [ES_BUS_WD-1:0] makeBundle(
      input logic [SIDE_WD-1:0] side, input logic [11:0] exc,
      input logic [31:0] badv, input logic req, input logic [2:0] ldType,
      input logic [1:0] addrLo, input logic [31:0] rtVal, input logic [3:0] grWe,
      input logic [4:0] dest, input logic [31:0] result, input logic [31:0] pc);
      return {side, exc, badv, req, ldType, addrLo, rtVal, grWe, dest, result, pc};
   endfunction

   // Reference result from the MIPS load rules using shifts and masks.
   function automatic logic [31:0] refResult(input logic [2:0] ldType, input logic [1:0] addrLo,
                                             input logic [31:0] rt, input logic [31:0] rdata,
                                             input logic [31:0] result);
      logic [31:0] b, h;
      int          sh;
      b = (rdata >> (8 * int'(addrLo))) & 32'hFF;
      h = (rdata >> (16 * (int'(addrLo) / 2))) & 32'hFFFF;
      case (ldType)
         3'd1: return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
         3'd2: return b;
         3'd3: return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
         3'd4: return h;
         3'd5: return rdata;
         3'd6: begin
            sh = 8 * (3 - int'(addrLo));
            return (rdata << sh) | (rt & ((32'h1 << sh) - 32'h1));
         end
         3'd7: begin
            sh = 8 * int'(addrLo);
            return (rdata >> sh) | (rt & ~(32'hFFFFFFFF >> sh));
         end
         default: return result;
      endcase
   endfunction

   // Scoreboard monitor: every WB handshake must match the oldest expectation.
   always @(negedge clk) begin
      if (resetn && ms_to_ws_valid && ws_allowin) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedOutput: got pc %0h, expected no output", ms_to_ws_bus[31:0]);
         end else begin
            expect_t e;
            e = expQ.pop_front();
            checkOutput("outPc",       ms_to_ws_bus[31:0],    e.pc);
            checkOutput("outResult",   ms_to_ws_bus[63:32],   e.value);
            checkOutput("outDest",     ms_to_ws_bus[68:64],   e.dest);
            checkOutput("outGrWe",     ms_to_ws_bus[72:69],   e.grWe);
            checkOutput("outBadvaddr", ms_to_ws_bus[104:73],  e.badvaddr);
            checkOutput("outExc",      ms_to_ws_bus[116:105], e.exc);
            checkOutput("outSide",     ms_to_ws_bus[WS_BUS_WD-1:117], e.side);
            checkOutput("fwdResult",   ms_fwd[31:0], e.value);
            checkOutput("fwdValid",    ms_fwd[42], |e.grWe);
         end
      end
   end

   // One instruction through MS: lat wait cycles before data_ok, and
   // ws_allowin held low for stall cycles once the result is ready.
   task automatic applyStimulus(input logic [2:0] ldType, input logic [1:0] addrLo,
                                input logic [31:0] rtVal, input logic [31:0] result,
                                input logic [31:0] pc, input logic [11:0] exc, input logic req,
                                input logic [31:0] rdata, input int lat, input int stall);
      expect_t e;
      logic    waits;
      int      guard;
      waits      = req && (exc == 12'h000);
      e.pc       = pc;
      e.exc      = exc;
      e.badvaddr = $urandom;
      e.grWe     = 4'($urandom);
      e.dest     = 5'($urandom);
      e.side     = {14'($urandom), $urandom};
      e.value    = refResult(ldType, addrLo, rtVal, rdata, result);
      es_to_ms_bus   = makeBundle(e.side, exc, e.badvaddr, req, ldType, addrLo, rtVal,
                                  e.grWe, e.dest, result, pc);
      es_to_ms_valid = 1'b1;
      guard = 0;
      @(negedge clk);
      while (!ms_allowin && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("acceptReady", ms_allowin, 1);
      expQ.push_back(e);
      @(posedge clk); #1;
      es_to_ms_valid = 1'b0;
      if (waits) begin
         for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            checkOutput("waitNoOutput", ms_to_ws_valid, 0);
            checkOutput("waitBlocked", ms_fwd[41], ldType != 3'd0);
            @(posedge clk); #1;
         end
         data_sram_data_ok = 1'b1;
         data_sram_rdata   = rdata;
         ws_allowin        = (stall == 0);
         @(negedge clk);
         checkOutput("dataOkValid", ms_to_ws_valid, 1);
         checkOutput("dataOkAllowin", ms_allowin, stall == 0);
         checkOutput("dataOkUnblocked", ms_fwd[41], 0);
         @(posedge clk); #1;
         data_sram_data_ok = 1'b0;
         data_sram_rdata   = $urandom;
         for (int i = 1; i < stall; i++) begin
            @(negedge clk);
            checkOutput("heldValid", ms_to_ws_valid, 1);
            checkOutput("heldAllowin", ms_allowin, 0);
            @(posedge clk); #1;
         end
         if (stall > 0) begin
            ws_allowin = 1'b1;
            @(negedge clk);
            checkOutput("releaseValid", ms_to_ws_valid, 1);
            @(posedge clk); #1;
         end
      end else begin
         ws_allowin = 1'b0;
         for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checkOutput("readyHeldValid", ms_to_ws_valid, 1);
            checkOutput("readyHeldAllowin", ms_allowin, 0);
            @(posedge clk); #1;
         end
         ws_allowin = 1'b1;
         @(negedge clk);
         checkOutput("readyValid", ms_to_ws_valid, 1);
         @(posedge clk); #1;
      end
   endtask

   // Flush a waiting load, accept a new one; the stale response must vanish.
   task automatic flushTest();
      expect_t e;
      es_to_ms_bus   = makeBundle('0, 12'h0, 32'h0, 1'b1, 3'd5, 2'd0, 32'h0, 4'hF, 5'd3,
                                  32'h0, 32'h0BAD0000);
      es_to_ms_valid = 1'b1;
      @(negedge clk);
      checkOutput("flushAcceptA", ms_allowin, 1);
      @(posedge clk); #1;
      es_to_ms_valid = 1'b0;
      @(negedge clk);
      checkOutput("flushWaitBlocked", ms_fwd[41], 1);
      @(posedge clk); #1;
      e.pc = 32'hBFC00200; e.exc = 12'h0; e.badvaddr = 32'h12340000; e.grWe = 4'hF;
      e.dest = 5'd7; e.side = 46'h155; e.value = refResult(3'd5, 2'd0, 32'h0, 32'h0000BEEF, 32'h0);
      flush          = 1'b1;
      es_to_ms_bus   = makeBundle(e.side, e.exc, e.badvaddr, 1'b1, 3'd5, 2'd0, 32'h0,
                                  e.grWe, e.dest, 32'h0, e.pc);
      es_to_ms_valid = 1'b1;
      @(negedge clk);
      checkOutput("flushCycleNoOutput", ms_to_ws_valid, 0);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      checkOutput("flushThenAllowin", ms_allowin, 1);
      expQ.push_back(e);
      @(posedge clk); #1;
      es_to_ms_valid    = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h0000DEAD;
      @(negedge clk);
      checkOutput("staleDropped", ms_to_ws_valid, 0);
      checkOutput("staleBlocked", ms_fwd[41], 1);
      @(posedge clk); #1;
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = $urandom;
      @(negedge clk);
      checkOutput("waitAfterStale", ms_to_ws_valid, 0);
      @(posedge clk); #1;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h0000BEEF;
      @(negedge clk);
      checkOutput("freshValid", ms_to_ws_valid, 1);
      @(posedge clk); #1;
      data_sram_data_ok = 1'b0;
   endtask

   // Flush coinciding with data_ok: the response is used up, nothing owed.
   task automatic flushWithDataOk();
      es_to_ms_bus   = makeBundle('0, 12'h0, 32'h0, 1'b1, 3'd5, 2'd0, 32'h0, 4'h1, 5'd2,
                                  32'h0, 32'h0BAD0100);
      es_to_ms_valid = 1'b1;
      @(negedge clk);
      checkOutput("fdAccept", ms_allowin, 1);
      @(posedge clk); #1;
      es_to_ms_valid    = 1'b0;
      flush             = 1'b1;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = $urandom;
      @(negedge clk);
      checkOutput("fdNoOutput", ms_to_ws_valid, 0);
      @(posedge clk); #1;
      flush             = 1'b0;
      data_sram_data_ok = 1'b0;
      applyStimulus(3'd5, 2'd0, 32'h0, 32'h0, 32'hBFC00300, 12'h0, 1'b1, 32'h13579BDF, 1, 0);
   endtask

   // Reset asserted while a load waits; outputs must clear at once.
   task automatic resetMidWait();
      es_to_ms_bus   = makeBundle('1, 12'h0, 32'hFFFFFFFF, 1'b1, 3'd5, 2'd0, 32'h1, 4'hF,
                                  5'd9, 32'h5, 32'hBFC00400);
      es_to_ms_valid = 1'b1;
      @(negedge clk);
      checkOutput("rstAccept", ms_allowin, 1);
      @(posedge clk); #1;
      es_to_ms_valid = 1'b0;
      @(negedge clk);
      checkOutput("rstWaitBlocked", ms_fwd[41], 1);
      #2 resetn = 1'b0;
      #1;
      checkOutput("rstValid", ms_to_ws_valid, 0);
      checkOutput("rstFwd", ms_fwd, 0);
      checkOutput("rstAllowin", ms_allowin, 1);
      checkOutput("rstBus", |ms_to_ws_bus, 0);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(negedge clk);
      checkOutput("rstReleaseAllowin", ms_allowin, 1);
      @(posedge clk); #1;
      applyStimulus(3'd5, 2'd0, 32'h0, 32'h0, 32'hBFC00500, 12'h0, 1'b1, 32'h2468ACE0, 0, 0);
   endtask

   initial begin
      resetn            = 1'b0;
      es_to_ms_valid    = 1'b0;
      es_to_ms_bus      = '0;
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'h0;
      flush             = 1'b0;
      ws_allowin        = 1'b1;
      #2;
      checkOutput("resetValid", ms_to_ws_valid, 0);
      checkOutput("resetFwd", ms_fwd, 0);
      checkOutput("resetAllowin", ms_allowin, 1);
      checkOutput("resetBus", |ms_to_ws_bus, 0);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      @(posedge clk); #1;

      applyStimulus(3'd5, 2'd0, 32'h0, 32'h0, 32'hBFC00100, 12'h0, 1'b1, 32'h12345678, 3, 0);
      applyStimulus(3'd5, 2'd0, 32'h0, 32'h0, 32'hBFC00104, 12'h0, 1'b1, 32'hCAFEF00D, 1, 2);
      applyStimulus(3'd1, 2'd2, 32'h0, 32'h0, 32'hBFC00108, 12'h0, 1'b1, 32'h0080FF00, 1, 0);
      applyStimulus(3'd2, 2'd2, 32'h0, 32'h0, 32'hBFC0010C, 12'h0, 1'b1, 32'h0080FF00, 0, 0);
      applyStimulus(3'd6, 2'd1, 32'hAABBCCDD, 32'h0, 32'hBFC00110, 12'h0, 1'b1, 32'h11223344, 2, 0);
      applyStimulus(3'd7, 2'd1, 32'hAABBCCDD, 32'h0, 32'hBFC00114, 12'h0, 1'b1, 32'h11223344, 0, 1);
      applyStimulus(3'd3, 2'd2, 32'h0, 32'h0, 32'hBFC00118, 12'h0, 1'b1, 32'h80011234, 1, 0);
      applyStimulus(3'd4, 2'd2, 32'h0, 32'h0, 32'hBFC0011C, 12'h0, 1'b1, 32'h80011234, 1, 0);
      applyStimulus(3'd0, 2'd0, 32'h0, 32'h00000055, 32'hBFC00120, 12'h002, 1'b1, $urandom, 0, 0);

      flushTest();
      flushWithDataOk();

      for (int t = 0; t < 60; t++) begin
         logic [2:0]  lt;
         logic [11:0] ex;
         logic        rq;
         lt = 3'($urandom_range(0, 7));
         ex = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(1, 4095)) : 12'h0;
         if (ex != 12'h0) lt = 3'd0;
         rq = (lt != 3'd0) ? 1'b1 : 1'($urandom);
         applyStimulus(lt, 2'($urandom), $urandom, $urandom, $urandom, ex, rq, $urandom,
                       $urandom_range(0, 3), $urandom_range(0, 2));
      end

      resetMidWait();

      repeat (3) @(posedge clk);
      #1;
      checkOutput("queueDrained", expQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage_sram.md
Name: mem_stage_sram

Overview:
- Memory stage of the 5-stage MIPS pipeline. Sits between the EX stage and the writeback/CP0 stage.
- Accepts an EX bundle and waits for the SRAM-like data bus response for any load or store issued in EX.
- Aligns and sign-extends load data (including LWL/LWR merge), produces the MS→WS bundle, and drives the MS forwarding bus to decode.
- Drops responses belonging to instructions flushed by an exception or ERET.

Parameters:
- SIDE_WD, 46, width of the pass-through field. Carries cp0_msg[41:0], at_delay_slot and tlb_type[2:0] to WB unchanged.
- ES_BUS_WD, SIDE_WD+155, width of es_to_ms_bus.
- WS_BUS_WD, SIDE_WD+117, width of ms_to_ws_bus.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- es_to_ms_valid  in  1  EX bundle valid
- es_to_ms_bus  in  ES_BUS_WD  EX bundle. Layout: [ES_BUS_WD-1:155] side; [154:143] exc; [142:111] badvaddr; [110] req (data request issued in EX); [109:107] ld_type; [106:105] addr_lo; [104:73] rt_val; [72:69] gr_we; [68:64] dest; [63:32] result; [31:0] pc
- ms_allowin  out  1  MS can accept a bundle this cycle
- data_sram_data_ok  in  1  one-cycle response strobe
- data_sram_rdata  in  32  read data, valid with data_ok
- flush  in  1  WB exception/ERET flush
- ws_allowin  in  1  WB can accept
- ms_to_ws_valid  out  1  bundle to WB valid
- ms_to_ws_bus  out  WS_BUS_WD  Layout: [WS_BUS_WD-1:117] side; [116:105] exc; [104:73] badvaddr; [72:69] gr_we; [68:64] dest; [63:32] final_result; [31:0] pc
- ms_fwd  out  43  {fwd_valid, fwd_blocked, gr_we[3:0], dest[4:0], final_result[31:0]}

Behaviour:
- Reset state (asynchronous, while resetn=0):
  - ms_valid=0, state=EMPTY, discard=0, buf_valid=0, latched bundle=0.
  - Outputs: ms_to_ws_valid=0, ms_fwd=0, ms_allowin=1, ms_to_ws_bus=0.
- States:
  - EMPTY: no valid instruction.
  - WAIT: valid, req=1, response not yet received.
  - READY: valid, data available or none needed.
- Acceptance:
  - ms_allowin = !ms_valid || (ready_go && ws_allowin).
  - On es_to_ms_valid && ms_allowin && !flush, latch the bundle.
  - Next state is WAIT if req && exc==0, else READY.
  - A bundle with exc≠0 is treated as req=0.
- ready_go is 1 in READY, or in WAIT on a cycle where data_ok=1 and discard=0. Same-cycle pass-through to WB is allowed.
- Response in WAIT:
  - data_ok with ws_allowin=0: capture rdata into buf, set buf_valid, go to READY.
  - Load data is taken from buf when buf_valid=1, else directly from data_sram_rdata.
  - buf_valid clears when the instruction leaves MS.
- Discard:
  - Flush while in WAIT (data_ok not yet seen) sets discard=1.
  - While discard=1, the next data_ok is consumed silently and clears discard. It never completes the current instruction, even if that instruction is a newly accepted WAIT.
  - At most one response can be pending; discard is 1 bit.
- Flush:
  - ms_valid←0 and state←EMPTY next cycle.
  - ms_to_ws_valid is forced 0 in the flush cycle.
  - es_to_ms_valid is ignored in the flush cycle.
  - Flush in the same cycle as data_ok: the response is consumed and discard is not set.
- Output valid: ms_to_ws_valid = ms_valid && ready_go && !flush.
- final_result, indexed by ld_type:
  - 0: result (non-load, including stores).
  - 1 lb / 2 lbu: byte at addr_lo, sign- or zero-extended.
  - 3 lh / 4 lhu: halfword at addr_lo[1], sign- or zero-extended.
  - 5 lw: rdata.
  - 6 lwl, n=addr_lo: {rdata[8n+7:0], rt_val[23-8n:0]}; n=3 gives rdata.
  - 7 lwr, n=addr_lo: {rt_val[31:32-8n], rdata[31:8n]}; n=0 gives rdata.
  - gr_we, dest, pc, exc, badvaddr and side pass through unchanged.
- Forwarding:
  - fwd_valid = ms_valid && |gr_we.
  - fwd_blocked = ms_valid && ld_type≠0 && !ready_go. Decode must stall on a match while blocked.

Test Plan:
- lw, pc=0xBFC00100, data_ok 3 cycles after acceptance with rdata=0x12345678, ws_allowin=1 → ms_to_ws_valid exactly in the data_ok cycle, final_result=0x12345678; fwd_blocked=1 during the 3 wait cycles.
- lw; data_ok arrives while ws_allowin=0 for 2 cycles → rdata buffered, ms_allowin=0; output appears with the correct value in the cycle ws_allowin rises.
- lb addr_lo=2, rdata=0x0080FF00 → 0xFFFFFF80. lbu → 0x00000080. lwl addr_lo=1, rt_val=0xAABBCCDD, rdata=0x11223344 → 0x3344CCDD. lwr addr_lo=1, same data → 0xAA112233.
- Load in WAIT, flush asserted, new lw accepted next cycle; first data_ok (rdata=0xDEAD) dropped, second data_ok (0xBEEF) → WB gets 0xBEEF only; flushed pc never appears.
- Bundle with exc=12'h002 and req=1 → READY immediately, no wait; exc and badvaddr forwarded intact.
- resetn low mid-WAIT → all outputs return to reset values immediately; after release, ms_allowin=1 and discard=0.
